// File: rtl/mux_word_serializer_pkg.sv
// Shared widths, select limits and FSM state type for the mux word serializer.
package mux_word_serializer_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned SEL_W  = 4;
    localparam int unsigned HOLD_W = 4;
    localparam int unsigned CNT_W  = 8;

    localparam logic [SEL_W-1:0] SEL_LAST = 4'b1111;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    // Terminal value of the per-index hold counter.
    function automatic logic [HOLD_W-1:0] hold_last(input int unsigned hold_cycles);
        return HOLD_W'(hold_cycles - 1);
    endfunction

endpackage

// File: rtl/mux16to1.sv
// Combinational 16:1 bit mux; in[0] is selected by sel=0000, sel[0] is the MSB.
module mux16to1 (
    input  logic [0:15] in,
    input  logic [0:3]  sel,
    output logic        out
);

    assign out = in[sel];

endmodule

// File: rtl/mux_word_serializer_sel_sequencer.sv
// Select-index stepper: holds each index HOLD_CYCLES cycles, then offers a bit.
module mux_sel_sequencer
    import mux_word_serializer_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             active,
    input  logic             restart,
    input  logic             advance,
    output logic [0:SEL_W-1] sel,
    output logic             ser_valid,
    output logic             ser_last
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = hold_last(HOLD_CYCLES);

    logic [HOLD_W-1:0] hold_cnt;

    // Counter saturates at HOLD_LAST so an unaccepted bit stays valid under backpressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel      <= '0;
            hold_cnt <= '0;
        end else if (restart) begin
            sel      <= '0;
            hold_cnt <= '0;
        end else if (advance && (sel != SEL_LAST)) begin
            sel      <= sel + SEL_W'(1);
            hold_cnt <= '0;
        end else if (active && (hold_cnt != HOLD_LAST)) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end

    always_comb begin
        ser_valid = active && (hold_cnt == HOLD_LAST);
        ser_last  = ser_valid && (sel == SEL_LAST);
    end

endmodule

// File: rtl/mux_word_serializer.sv
// Word-to-bit serializer wrapped around an external mux16to1: holds the word on
// mux_in, steps sel 0..15 and streams mux_out back out with valid/ready.
module mux_word_serializer
    import mux_word_serializer_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [0:WORD_W-1] load_data,
    output logic [0:WORD_W-1] mux_in,
    output logic [0:SEL_W-1]  sel,
    input  logic              mux_out,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_bit,
    output logic              ser_last,
    output logic              busy,
    output logic [CNT_W-1:0]  words_done
);

    state_t state;
    logic   xfer;
    logic   word_end;
    logic   accept;

    // Ready reopens during the final transfer so the next word follows with no gap.
    always_comb begin
        xfer       = ser_valid && ser_ready;
        word_end   = xfer && ser_last;
        load_ready = (state == S_IDLE) || word_end;
        accept     = load_valid && load_ready;
    end

    assign ser_bit = mux_out;
    assign busy    = (state == S_SHIFT);

    mux_sel_sequencer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .active   (busy),
        .restart  (accept),
        .advance  (xfer && !ser_last),
        .sel      (sel),
        .ser_valid(ser_valid),
        .ser_last (ser_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            mux_in     <= '0;
            words_done <= '0;
        end else begin
            if (accept) begin
                mux_in <= load_data;
            end
            if (word_end) begin
                words_done <= words_done + CNT_W'(1);
            end
            case (state)
                S_IDLE:  if (accept) state <= S_SHIFT;
                S_SHIFT: if (word_end && !accept) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_word_serializer.sv
// Self-checking bench: serializer + mux16to1 pairs at HOLD_CYCLES=1 and 3.
module tb_mux_word_serializer;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        a_lv, a_lr, a_mo, a_sv, a_sr, a_sb, a_sl, a_busy;
    logic [0:15] a_ld, a_mi;
    logic [0:3]  a_sel;
    logic [7:0]  a_wd;

    logic        b_lv, b_lr, b_mo, b_sv, b_sr, b_sb, b_sl, b_busy;
    logic [0:15] b_ld, b_mi;
    logic [0:3]  b_sel;
    logic [7:0]  b_wd;

    int total = 0;
    int bad   = 0;
    int a_words = 0;
    int b_cyc, b_n;
    logic [15:0] bw, rw;

    always #5 clk = ~clk;

    mux_word_serializer #(.HOLD_CYCLES(1)) u_a (
        .clk(clk), .rst_n(rst_n), .load_valid(a_lv), .load_ready(a_lr),
        .load_data(a_ld), .mux_in(a_mi), .sel(a_sel), .mux_out(a_mo),
        .ser_valid(a_sv), .ser_ready(a_sr), .ser_bit(a_sb), .ser_last(a_sl),
        .busy(a_busy), .words_done(a_wd)
    );
    mux16to1 u_ma (.in(a_mi), .sel(a_sel), .out(a_mo));

    mux_word_serializer #(.HOLD_CYCLES(3)) u_b (
        .clk(clk), .rst_n(rst_n), .load_valid(b_lv), .load_ready(b_lr),
        .load_data(b_ld), .mux_in(b_mi), .sel(b_sel), .mux_out(b_mo),
        .ser_valid(b_sv), .ser_ready(b_sr), .ser_bit(b_sb), .ser_last(b_sl),
        .busy(b_busy), .words_done(b_wd)
    );
    mux16to1 u_mb (.in(b_mi), .sel(b_sel), .out(b_mo));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic a_accept(input logic [15:0] word);
        @(negedge clk);
        a_lv = 1'b1;
        a_ld = word;
        a_sr = 1'b1;
        #1;
        check("a_ready_idle", 32'(a_lr), 32'd1);
        check("a_valid_idle", 32'(a_sv), 32'd0);
    endtask

    // Expected stream: bit i of the word (i=0 is the literal MSB) on the i-th transfer.
    task automatic a_stream(input logic [15:0] word, input int stall_sel, input int stall_n,
                            input bit rnd, input bit chain, input logic [15:0] chain_word,
                            input int stop_at);
        int idx = 0;
        int cyc = 0;
        int stalls = stall_n;
        while (idx < stop_at && cyc < 400) begin
            @(negedge clk);
            cyc++;
            a_lv = chain && (idx == 15);
            a_ld = a_lv ? chain_word : 16'($urandom);
            if (idx == stall_sel && stalls > 0) begin
                a_sr = 1'b0;
                stalls--;
            end else begin
                a_sr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            #1;
            check("a_valid", 32'(a_sv), 32'd1);
            check("a_busy", 32'(a_busy), 32'd1);
            check("a_sel", 32'(a_sel), 32'(idx));
            check("a_bit", 32'(a_sb), 32'(word[15-idx]));
            check("a_last", 32'(a_sl), 32'(idx == 15));
            check("a_load_ready", 32'(a_lr), 32'(idx == 15 && a_sr));
            if (a_sr) idx++;
        end
        check("a_stream_done", 32'(idx), 32'(stop_at));
        if (stop_at == 16) a_words = (a_words + 1) % 256;
    endtask

    task automatic a_finish();
        @(negedge clk);
        a_lv = 1'b0;
        a_sr = 1'b1;
        #1;
        check("a_busy_end", 32'(a_busy), 32'd0);
        check("a_valid_end", 32'(a_sv), 32'd0);
        check("a_ready_end", 32'(a_lr), 32'd1);
        check("a_words_done", 32'(a_wd), 32'(a_words));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        a_lv = 1'b0; a_ld = '0; a_sr = 1'b0;
        b_lv = 1'b0; b_ld = '0; b_sr = 1'b0;

        // 1: power-on reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_sel", 32'(a_sel), 32'd0);
        check("rst_valid", 32'(a_sv), 32'd0);
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_words", 32'(a_wd), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("rst_ready", 32'(a_lr), 32'd1);

        // 2: single word, full-rate
        a_accept(16'hA5C3);
        a_stream(16'hA5C3, -1, 0, 1'b0, 1'b0, 16'h0, 16);
        a_finish();

        // 1b: reset mid-idle clears words_done
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        a_words = 0;
        #1;
        check("rst2_words", 32'(a_wd), 32'd0);
        check("rst2_sel", 32'(a_sel), 32'd0);
        check("rst2_ready", 32'(a_lr), 32'd1);

        // 3: backpressure at sel=3 for 3 cycles
        a_accept(16'hC3A5);
        a_stream(16'hC3A5, 3, 3, 1'b0, 1'b0, 16'h0, 16);
        a_finish();

        // 4: back-to-back words
        a_accept(16'h8001);
        a_stream(16'h8001, -1, 0, 1'b0, 1'b1, 16'hFFFF, 16);
        a_stream(16'hFFFF, -1, 0, 1'b0, 1'b0, 16'h0, 16);
        a_finish();

        // 5: HOLD_CYCLES=3
        bw = 16'h0F0F;
        @(negedge clk);
        b_lv = 1'b1;
        b_ld = bw;
        b_sr = 1'b1;
        #1;
        check("b_ready", 32'(b_lr), 32'd1);
        b_cyc = 0;
        b_n = 0;
        while (b_n < 16 && b_cyc < 200) begin
            @(negedge clk);
            b_lv = 1'b0;
            b_ld = 16'($urandom);
            #1;
            check("b_valid", 32'(b_sv), 32'((b_cyc % 3) == 2));
            if (b_sv) begin
                check("b_bit", 32'(b_sb), 32'(bw[15-b_n]));
                check("b_last", 32'(b_sl), 32'(b_n == 15));
                b_n++;
            end
            b_cyc++;
        end
        check("b_cycles", 32'(b_cyc), 32'd48);
        @(negedge clk);
        #1;
        check("b_busy_end", 32'(b_busy), 32'd0);
        check("b_words_done", 32'(b_wd), 32'd1);

        // 6: reset mid-word at sel=7, then a clean word
        a_accept(16'h5A96);
        a_stream(16'h5A96, -1, 0, 1'b0, 1'b0, 16'h0, 7);
        @(negedge clk);
        rst_n = 1'b0;
        a_lv = 1'b0;
        a_sr = 1'b1;
        #1;
        check("t6_sel_mid", 32'(a_sel), 32'd7);
        @(negedge clk);
        rst_n = 1'b1;
        a_words = 0;
        #1;
        check("t6_sel", 32'(a_sel), 32'd0);
        check("t6_valid", 32'(a_sv), 32'd0);
        check("t6_busy", 32'(a_busy), 32'd0);
        check("t6_words", 32'(a_wd), 32'd0);
        check("t6_b_words", 32'(b_wd), 32'd0);
        a_accept(16'h1234);
        a_stream(16'h1234, -1, 0, 1'b0, 1'b0, 16'h0, 16);
        a_finish();

        // random words with random backpressure
        for (int k = 0; k < 6; k++) begin
            rw = 16'($urandom);
            a_accept(rw);
            a_stream(rw, $urandom_range(0, 15), $urandom_range(0, 4), 1'b1, 1'b0, 16'h0, 16);
            a_finish();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
